// File: rtl/chunk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chunk_pkg
// Description : Shared constants, mode encoding and FSM state type for the
//               chunk assembler / chunk divider pair.
// Revision    : 1.0 - initial release
// ============================================================================
package chunk_pkg;

    localparam int WORD_W      = 32;
    localparam int CHUNK_WORDS = 16;
    localparam int KEY_WORDS   = 8;
    localparam int NONCE_WORDS = 2;
    localparam int CTR_WORDS   = 2;

    localparam logic ENCRYP = 1'b0;
    localparam logic DECRYP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_NONCE = 3'd2,
        ST_CTR   = 3'd3,
        ST_DATA  = 3'd4,
        ST_OUT   = 3'd5
    } chunk_state_t;

endpackage
`default_nettype wire

// File: rtl/word_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : word_shift_reg
// Description : MSW-first word collector: each load lands one slot lower,
//               starting from the top word. Tracks the load count and flags
//               when the next load fills the register.
// Revision    : 1.0 - initial release
// ============================================================================
module word_shift_reg #(
    parameter int WORDS  = 2,
    parameter int WORD_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       load,
    input  logic [WORD_W-1:0]          din,
    output logic [WORDS*WORD_W-1:0]    data,
    output logic [$clog2(WORDS+1)-1:0] count,
    output logic                       last_word
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = $clog2(WORDS + 1);
    localparam logic [IW-1:0] TOP_IDX  = IW'(WORDS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    logic [WORDS*WORD_W-1:0] r_data;
    logic [IW-1:0]           r_idx;
    logic [CW-1:0]           r_cnt;

    // A clear and a load in the same cycle start a fresh fill with din on top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_idx  <= TOP_IDX;
            r_cnt  <= '0;
        end else if (clear) begin
            r_data <= '0;
            r_idx  <= TOP_IDX;
            r_cnt  <= '0;
            if (load) begin
                r_data[TOP_IDX*WORD_W +: WORD_W] <= din;
                r_idx <= TOP_IDX - IW'(1);
                r_cnt <= CW'(1);
            end
        end else if (load) begin
            r_data[r_idx*WORD_W +: WORD_W] <= din;
            r_idx <= r_idx - IW'(1);
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign data      = r_data;
    assign count     = r_cnt;
    assign last_word = (r_cnt == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/chunk_assembler.sv
`default_nettype none
// ============================================================================
// Module      : chunk_assembler
// Description : Packs 32-bit AXI-Stream words into 512-bit chunks, stripping
//               the key/nonce/counter header in decrypt mode.
//               Optional macro CHUNK_ASM_PAD_EN: zero-pad short final chunks
//               and expose chunk_asm_word_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_assembler #(
    parameter int CHUNK_WORDS = chunk_pkg::CHUNK_WORDS,
    parameter int KEY_WORDS   = chunk_pkg::KEY_WORDS,
    parameter int NONCE_WORDS = chunk_pkg::NONCE_WORDS,
    parameter int CTR_WORDS   = chunk_pkg::CTR_WORDS
) (
    input  logic                                   chunk_asm_clk,
    input  logic                                   chunk_asm_reset_n,
    input  logic                                   encryp_decryp,
    input  logic [chunk_pkg::WORD_W-1:0]           s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    input  logic                                   s_axis_tlast,
    output logic                                   s_axis_tready,
    input  logic                                   chunk_asm_ready,
    output logic [CHUNK_WORDS*chunk_pkg::WORD_W-1:0] chunk_asm_data_out,
    output logic                                   chunk_asm_valid,
    output logic [KEY_WORDS*chunk_pkg::WORD_W-1:0] chunk_asm_public_key,
    output logic [NONCE_WORDS*chunk_pkg::WORD_W-1:0] chunk_asm_nonce,
    output logic [CTR_WORDS*chunk_pkg::WORD_W-1:0] chunk_asm_counter,
    output logic                                   chunk_asm_last,
`ifdef CHUNK_ASM_PAD_EN
    output logic [$clog2(CHUNK_WORDS+1)-1:0]       chunk_asm_word_cnt,
`endif
    output logic                                   chunk_asm_err
);

    import chunk_pkg::*;

    localparam int CHUNK_W = CHUNK_WORDS * WORD_W;
    localparam int KEY_W   = KEY_WORDS * WORD_W;
    localparam int NONCE_W = NONCE_WORDS * WORD_W;
    localparam int CTR_W   = CTR_WORDS * WORD_W;

    chunk_state_t r_state;
    chunk_state_t w_state_next;

    logic               r_dec;
    logic               r_last;
    logic               r_err;
    logic [KEY_W-1:0]   r_key;
    logic [NONCE_W-1:0] r_nonce;
    logic [CTR_W-1:0]   r_counter;

    logic w_beat;
    logic w_hs;
    logic w_key_clr, w_key_ld;
    logic w_nonce_clr, w_nonce_ld;
    logic w_ctr_clr, w_ctr_ld;
    logic w_data_clr, w_data_ld;
    logic w_hdr_commit;
    logic w_chunk_done;
    logic w_err_set;

    logic [KEY_W-1:0]                     w_key_data;
    logic [NONCE_W-1:0]                   w_nonce_data;
    logic [CTR_W-1:0]                     w_ctr_data;
    logic [CHUNK_W-1:0]                   w_data_buf;
    logic [$clog2(KEY_WORDS+1)-1:0]       w_key_cnt;
    logic [$clog2(NONCE_WORDS+1)-1:0]     w_nonce_cnt;
    logic [$clog2(CTR_WORDS+1)-1:0]       w_ctr_cnt;
    logic [$clog2(CHUNK_WORDS+1)-1:0]     w_data_cnt;
    logic w_key_last, w_nonce_last, w_ctr_last, w_data_last;
    logic w_data_done;

    assign s_axis_tready = (r_state != ST_OUT);
    assign w_beat        = s_axis_tvalid & s_axis_tready;
    assign w_hs          = (r_state == ST_OUT) & chunk_asm_ready;
    // Data buffer count can be stale outside DATA after a discarded frame.
    assign w_data_done   = w_data_last & (r_state == ST_DATA);

    word_shift_reg #(.WORDS(KEY_WORDS), .WORD_W(WORD_W)) u_key_sr (
        .clk       (chunk_asm_clk),
        .rst_n     (chunk_asm_reset_n),
        .clear     (w_key_clr),
        .load      (w_key_ld),
        .din       (s_axis_tdata),
        .data      (w_key_data),
        .count     (w_key_cnt),
        .last_word (w_key_last)
    );

    word_shift_reg #(.WORDS(NONCE_WORDS), .WORD_W(WORD_W)) u_nonce_sr (
        .clk       (chunk_asm_clk),
        .rst_n     (chunk_asm_reset_n),
        .clear     (w_nonce_clr),
        .load      (w_nonce_ld),
        .din       (s_axis_tdata),
        .data      (w_nonce_data),
        .count     (w_nonce_cnt),
        .last_word (w_nonce_last)
    );

    word_shift_reg #(.WORDS(CTR_WORDS), .WORD_W(WORD_W)) u_ctr_sr (
        .clk       (chunk_asm_clk),
        .rst_n     (chunk_asm_reset_n),
        .clear     (w_ctr_clr),
        .load      (w_ctr_ld),
        .din       (s_axis_tdata),
        .data      (w_ctr_data),
        .count     (w_ctr_cnt),
        .last_word (w_ctr_last)
    );

    word_shift_reg #(.WORDS(CHUNK_WORDS), .WORD_W(WORD_W)) u_data_sr (
        .clk       (chunk_asm_clk),
        .rst_n     (chunk_asm_reset_n),
        .clear     (w_data_clr),
        .load      (w_data_ld),
        .din       (s_axis_tdata),
        .data      (w_data_buf),
        .count     (w_data_cnt),
        .last_word (w_data_last)
    );

    always_ff @(posedge chunk_asm_clk or negedge chunk_asm_reset_n) begin
        if (!chunk_asm_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_key_clr    = 1'b0;
        w_key_ld     = 1'b0;
        w_nonce_clr  = 1'b0;
        w_nonce_ld   = 1'b0;
        w_ctr_clr    = 1'b0;
        w_ctr_ld     = 1'b0;
        w_data_clr   = 1'b0;
        w_data_ld    = 1'b0;
        w_hdr_commit = 1'b0;
        w_chunk_done = 1'b0;
        w_err_set    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    if (encryp_decryp == DECRYP) begin
                        w_key_clr = 1'b1;
                        w_key_ld  = 1'b1;
                        if (s_axis_tlast) begin
                            w_err_set    = 1'b1;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next = ST_KEY;
                        end
                    end else begin
                        w_data_clr = 1'b1;
                        w_data_ld  = 1'b1;
                    end
                end
            end
            ST_KEY: begin
                if (w_beat) begin
                    w_key_ld = 1'b1;
                    if (s_axis_tlast) begin
                        w_err_set    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (w_key_last) begin
                        w_nonce_clr  = 1'b1;
                        w_state_next = ST_NONCE;
                    end
                end
            end
            ST_NONCE: begin
                if (w_beat) begin
                    w_nonce_ld = 1'b1;
                    if (s_axis_tlast) begin
                        w_err_set    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (w_nonce_last) begin
                        w_ctr_clr    = 1'b1;
                        w_state_next = ST_CTR;
                    end
                end
            end
            ST_CTR: begin
                if (w_beat) begin
                    w_ctr_ld = 1'b1;
                    if (s_axis_tlast) begin
                        w_err_set    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (w_ctr_last) begin
                        w_hdr_commit = 1'b1;
                        w_data_clr   = 1'b1;
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_beat) begin
                    w_data_ld = 1'b1;
                end
            end
            ST_OUT: begin
                if (w_hs) begin
                    w_data_clr   = 1'b1;
                    w_state_next = r_last ? ST_IDLE : ST_DATA;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Shared outcome of any payload beat, whether it opened the frame or not.
        if (w_data_ld) begin
            if (w_data_done) begin
                w_chunk_done = 1'b1;
                w_state_next = ST_OUT;
            end else if (s_axis_tlast) begin
`ifdef CHUNK_ASM_PAD_EN
                w_chunk_done = 1'b1;
                w_state_next = ST_OUT;
`else
                w_err_set    = 1'b1;
                w_state_next = ST_IDLE;
`endif
            end else begin
                w_state_next = ST_DATA;
            end
        end
    end

    always_ff @(posedge chunk_asm_clk or negedge chunk_asm_reset_n) begin
        if (!chunk_asm_reset_n) begin
            r_dec     <= ENCRYP;
            r_last    <= 1'b0;
            r_err     <= 1'b0;
            r_key     <= '0;
            r_nonce   <= '0;
            r_counter <= '0;
        end else begin
            if (r_state == ST_IDLE && w_beat) begin
                r_dec <= encryp_decryp;
            end
            if (w_chunk_done) begin
                r_last <= s_axis_tlast;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            // Side data is published only once a whole header has arrived.
            if (w_hdr_commit) begin
                r_key     <= w_key_data;
                r_nonce   <= w_nonce_data;
                r_counter <= {w_ctr_data[CTR_W-1:WORD_W], s_axis_tdata};
            end else if (w_hs && !r_last && r_dec) begin
                r_counter <= r_counter + CTR_W'(1);
            end
        end
    end

    assign chunk_asm_data_out   = w_data_buf;
    assign chunk_asm_valid      = (r_state == ST_OUT);
    assign chunk_asm_public_key = r_key;
    assign chunk_asm_nonce      = r_nonce;
    assign chunk_asm_counter    = r_counter;
    assign chunk_asm_last       = r_last;
    assign chunk_asm_err        = r_err;

`ifdef CHUNK_ASM_PAD_EN
    assign chunk_asm_word_cnt = w_data_cnt;
    logic w_unused_bits;
    assign w_unused_bits = ^{w_key_cnt, w_nonce_cnt, w_ctr_cnt, w_ctr_data[WORD_W-1:0]};
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{w_key_cnt, w_nonce_cnt, w_ctr_cnt, w_data_cnt,
                             w_ctr_data[WORD_W-1:0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_chunk_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunk_assembler
// Description : Scoreboard bench for chunk_assembler with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunk_assembler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic [31:0]  tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;
    logic         ready;
    logic [511:0] dout;
    logic         valid;
    logic [255:0] key;
    logic [63:0]  nonce;
    logic [63:0]  ctr;
    logic         last;
    logic         err;
`ifdef CHUNK_ASM_PAD_EN
    logic [4:0]   wcnt;
`endif

    always #5 clk = ~clk;

    chunk_assembler dut (
        .chunk_asm_clk        (clk),
        .chunk_asm_reset_n    (rst_n),
        .encryp_decryp        (mode),
        .s_axis_tdata         (tdata),
        .s_axis_tvalid        (tvalid),
        .s_axis_tlast         (tlast),
        .s_axis_tready        (tready),
        .chunk_asm_ready      (ready),
        .chunk_asm_data_out   (dout),
        .chunk_asm_valid      (valid),
        .chunk_asm_public_key (key),
        .chunk_asm_nonce      (nonce),
        .chunk_asm_counter    (ctr),
        .chunk_asm_last       (last),
`ifdef CHUNK_ASM_PAD_EN
        .chunk_asm_word_cnt   (wcnt),
`endif
        .chunk_asm_err        (err)
    );

    typedef struct {
        logic [511:0] data;
        logic [255:0] key;
        logic [63:0]  nonce;
        logic [63:0]  ctr;
        logic         last;
        logic [4:0]   wcnt;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    logic [255:0] cur_key;
    logic [63:0]  cur_nonce;
    logic [63:0]  cur_ctr;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [511:0] mk_chunk(input logic [31:0] base, input int n);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[(15-i)*32 +: 32] = base + i;
        return d;
    endfunction

    task automatic push(input logic [511:0] d, input logic l, input logic [4:0] wc);
        exp_t e;
        e.data = d; e.key = cur_key; e.nonce = cur_nonce; e.ctr = cur_ctr;
        e.last = l; e.wcnt = wc;
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send(input logic [31:0] d, input logic l);
        int guard;
        guard = 0;
        tdata = d; tlast = l; tvalid = 1'b1;
        while (!tready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!tready) begin
            n_vec++; n_mis++;
            $display("FAIL send_timeout: got tready=0 required tready=1 for word %0h", d);
        end
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_words(input logic [31:0] base, input int n, input logic last_at_end);
        for (int i = 0; i < n; i++) send(base + i, last_at_end && (i == n - 1));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_queue", 512'(q.size()), 512'd0);
    endtask

    // Monitor: every accepted chunk must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid && ready) begin
            if (q.size() == 0) begin
                n_vec++; n_mis++;
                $display("FAIL unexpected_chunk: got chunk with top word %0h required no chunk", dout[511:480]);
            end else begin
                e = q.pop_front();
                chk("chunk_data", dout, e.data);
                chk("chunk_key", 512'(key), 512'(e.key));
                chk("chunk_nonce", 512'(nonce), 512'(e.nonce));
                chk("chunk_counter", 512'(ctr), 512'(e.ctr));
                chk("chunk_last", 512'(last), 512'(e.last));
`ifdef CHUNK_ASM_PAD_EN
                chk("chunk_word_cnt", 512'(wcnt), 512'(e.wcnt));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0; ready = 1'b1;
        cur_key = '0; cur_nonce = '0; cur_ctr = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 512'(valid), 512'd0);
        chk("rst_outputs", {dout[255:0], key}, 512'd0);
        chk("rst_side", {ctr, nonce, last, err}, 512'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tready", 512'(tready), 512'd1);

        // Encrypt, one full chunk
        push(mk_chunk(32'h1, 16), 1'b1, 5'd16);
        mode = 1'b0;
        send_words(32'h1, 16, 1'b1);
        chk("valid_latency", 512'(valid), 512'd1);
        chk("enc_top_word", 512'(dout[511:480]), 512'h1);
        chk("enc_low_word", 512'(dout[31:0]), 512'h10);
        drain();

        // Decrypt, two chunks with counter carry into the upper word
        mode = 1'b1;
        send(32'hA0, 1'b0);
        mode = 1'b0;
        send_words(32'hA1, 7, 1'b0);
        send(32'hB0, 1'b0);
        send(32'hB1, 1'b0);
        send(32'h0, 1'b0);
        cur_key   = {32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        cur_nonce = {32'hB0, 32'hB1};
        cur_ctr   = 64'h0000_0000_FFFF_FFFF;
        push(mk_chunk(32'h100, 16), 1'b0, 5'd16);
        cur_ctr   = 64'h0000_0001_0000_0000;
        push(mk_chunk(32'h110, 16), 1'b1, 5'd16);
        send(32'hFFFF_FFFF, 1'b0);
        send_words(32'h100, 32, 1'b1);
        drain();

        // Backpressure: output held for 10 cycles, next beat waits for handshake
        mode = 1'b0;
        ready = 1'b0;
        push(mk_chunk(32'h500, 16), 1'b0, 5'd16);
        push(mk_chunk(32'h510, 16), 1'b1, 5'd16);
        send_words(32'h500, 16, 1'b0);
        fork
            send_words(32'h510, 16, 1'b1);
            begin
                for (int k = 0; k < 10; k++) begin
                    chk("hold_ready_valid", 512'({tready, valid, last}), 512'b010);
                    chk("hold_data", dout, mk_chunk(32'h500, 16));
                    chk("hold_side", {key, nonce, ctr}, {128'd0, cur_key, cur_nonce, cur_ctr});
                    @(negedge clk);
                end
                @(posedge clk);
                #1 ready = 1'b1;
            end
        join
        drain();

        // Header truncated by tlast on nonce word 1
        mode = 1'b1;
        send_words(32'hC0, 8, 1'b0);
        send(32'hD0, 1'b0);
        send(32'hD1, 1'b1);
        repeat (3) @(negedge clk);
        chk("hdr_err", 512'({err, valid}), 512'b10);
        mode = 1'b0;
        push(mk_chunk(32'h400, 16), 1'b1, 5'd16);
        send_words(32'h400, 16, 1'b1);
        drain();

        // Asynchronous reset mid-DATA, then a clean frame
        mode = 1'b0;
        send_words(32'h600, 7, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_clear", {dout[255:0], key}, 512'd0);
        chk("async_rst_flags", 512'({err, valid, tready, ctr}), 512'({1'b0, 1'b0, 1'b1, 64'd0}));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cur_key = '0; cur_nonce = '0; cur_ctr = '0;
        push(mk_chunk(32'h700, 16), 1'b1, 5'd16);
        send_words(32'h700, 16, 1'b1);
        drain();

        // Short final chunk of 5 words
`ifdef CHUNK_ASM_PAD_EN
        push(mk_chunk(32'h300, 5), 1'b1, 5'd5);
        send_words(32'h300, 5, 1'b1);
        chk("pad_low_zero", 512'(dout[351:0]), 512'd0);
        drain();
        chk("pad_no_err", 512'(err), 512'd0);
`else
        send_words(32'h300, 5, 1'b1);
        repeat (3) @(negedge clk);
        chk("short_err", 512'({err, valid, tready}), 512'b101);
`endif
        push(mk_chunk(32'h800, 16), 1'b1, 5'd16);
        send_words(32'h800, 16, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chunk_assembler.md
Name: chunk_assembler

Overview:
- Upstream neighbour of the chunk divider.
- Collects 32-bit AXI-Stream words from the DMA into 512-bit chunks for the cipher core.
- In decrypt mode it first strips and captures the frame header: public key (8 words), nonce (2 words), counter (2 words). In encrypt mode the stream is payload only.
- Presents each complete chunk, with its key/nonce/counter, through a valid/ready handshake.

Parameters:
- CHUNK_WORDS, 16, 32-bit words per chunk.
- KEY_WORDS, 8, public-key header words (decrypt).
- NONCE_WORDS, 2, nonce header words.
- CTR_WORDS, 2, counter header words.

Ports:
- chunk_asm_clk  in  1  sole clock.
- chunk_asm_reset_n  in  1  asynchronous, active-low reset.
- encryp_decryp  in  1  0=encrypt, 1=decrypt; sampled on first word of frame.
- s_axis_tdata  in  32  input word, most-significant word first.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tlast  in  1  last word of frame.
- s_axis_tready  out  1  assembler can accept a word.
- chunk_asm_ready  in  1  downstream accepts chunk.
- chunk_asm_data_out  out  512  assembled chunk; first word lands in [511:480].
- chunk_asm_valid  out  1  chunk and side data valid.
- chunk_asm_public_key  out  256  captured key; first header word in [255:224].
- chunk_asm_nonce  out  64  captured nonce.
- chunk_asm_counter  out  64  block counter for the presented chunk.
- chunk_asm_last  out  1  presented chunk is final chunk of frame.
- chunk_asm_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: all outputs 0 except s_axis_tready. s_axis_tready=1 from first cycle after reset release. FSM in IDLE.
- Reset asserted mid-frame discards the partial chunk and header immediately (asynchronous).
- A word transfers when s_axis_tvalid & s_axis_tready on a rising edge. tready = 1 in all states except OUT.
- FSM states: IDLE, KEY, NONCE, CTR, DATA, OUT.
- IDLE:
  - On first beat, latch mode.
  - Decrypt: store the word as key word 0, go to KEY.
  - Encrypt: store as data word 0, go to DATA.
- KEY, NONCE, CTR:
  - Shift words in MSW-first; an index counts down.
  - Advance to the next header state after KEY_WORDS / NONCE_WORDS / CTR_WORDS beats, then to DATA.
- DATA: shift words in. On the CHUNK_WORDS-th beat go to OUT and set chunk_asm_valid the next cycle (1-cycle latency from last beat).
- OUT:
  - chunk_asm_valid, chunk_asm_data_out, chunk_asm_public_key, chunk_asm_nonce, chunk_asm_counter and chunk_asm_last are held stable until chunk_asm_ready=1.
  - On the handshake cycle, valid drops next cycle.
  - chunk_asm_last=1: go to IDLE.
  - chunk_asm_last=0: increment chunk_asm_counter by 1 (64-bit modulo wrap, FFFF_FFFF_FFFF_FFFF -> 0) and go to DATA.
  - The next chunk of the same frame reuses the key and nonce.
- chunk_asm_last = tlast of the beat that completed the chunk.
- Encrypt mode: key/nonce/counter outputs are not updated. They retain their last decrypt values, or 0 after reset.
- tlast during KEY, NONCE or CTR: set chunk_asm_err, discard the frame, return to IDLE, emit no chunk.
- tlast in DATA before CHUNK_WORDS beats: see Optional Feature.
- Mode changes after the first beat are ignored until IDLE.
- chunk_asm_err clears only on reset.

Optional Feature:
- Macro CHUNK_ASM_PAD_EN.
- Defined:
  - A short final chunk (tlast before the 16th beat) is zero-filled in the remaining low words and emitted with chunk_asm_last=1.
  - Adds output chunk_asm_word_cnt [4:0] = number of real words (1..16), valid with chunk_asm_valid.
- Not defined: a short final chunk sets chunk_asm_err, is discarded, and the FSM returns to IDLE.

Decomposition:
- Shared package chunk_pkg:
  - ENCRYP/DECRYP mode constants.
  - Word width 32, CHUNK_WORDS, KEY_WORDS, NONCE_WORDS, CTR_WORDS.
  - FSM state encoding.
  - Also used by the chunk divider.
- One natural sub-module, word_shift_reg: a parameterised MSW-first 32-bit shift-in register with load count and done flag. Instantiated for the header fields and the data buffer.
- The FSM stays in chunk_assembler.

Test Plan:
- Encrypt, 16 beats 0x00000001..0x00000010 with tlast on beat 16, ready=1 -> one chunk: [511:480]=0x1, [31:0]=0x10; last=1; valid 1 cycle after beat 16.
- Decrypt, key words 0xA0..0xA7, nonce 0xB0,0xB1, counter 0x0,0xFFFFFFFF, then 32 data beats -> chunk 1 counter=0x00000000FFFFFFFF, chunk 2 counter=0x0000000100000000; key and nonce identical on both; last only on chunk 2.
- Hold chunk_asm_ready=0 for 10 cycles in OUT -> tready=0 and all outputs stable throughout; the 17th input beat is not accepted until the handshake.
- Decrypt with tlast on nonce word 1 -> err=1, no valid pulse; the next encrypt frame then assembles normally.
- Short frame of 5 beats -> with CHUNK_ASM_PAD_EN: word_cnt=5 and [351:0]=0. Without the macro: err=1 and no chunk.
- Reset asserted mid-DATA at beat 7, then a full encrypt frame -> only the new frame's chunk is emitted, containing no stale words.
